// File: rtl/reg_bank_bus_arbiter_if.sv
// Shared register-load bus between the requesters and the bus arbiter.
//
// Handshake: a requester raises req[i] with req_dst/req_data slice i
// stable and holds all three until ack[i] pulses for one cycle. It drops
// req[i] by the clock edge that ends the ack cycle. A req[i] still high in
// the following IDLE cycle counts as a new request. clr_req is level-sampled
// in IDLE and must be dropped by the edge that ends the bank_clr_n-low cycle.
interface reg_bank_bus_arbiter_if #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int DW   = 8
);
    localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DSTW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NREQ-1:0]      req;
    logic [NREQ*DSTW-1:0] req_dst;
    logic [NREQ*DW-1:0]   req_data;
    logic                 clr_req;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        bus_data;
    logic [SW-1:0]        bus_sel;
    logic [NREG-1:0]      reg_load;
    logic                 bank_clr_n;
    logic                 busy;
    logic [2:0]           dbg_state;

    // Arbiter side.
    modport slave (
        input  req, req_dst, req_data, clr_req,
        output ack, bus_data, bus_sel, reg_load, bank_clr_n, busy, dbg_state
    );

    // Requester / register-bank side.
    modport master (
        output req, req_dst, req_data, clr_req,
        input  ack, bus_data, bus_sel, reg_load, bank_clr_n, busy, dbg_state
    );
endinterface

// File: rtl/reg_bank_bus_arbiter.sv
// Round-robin arbiter for a shared register-load bus. Each transfer runs
// SETUP (data on bus) -> LOAD (one-hot load strobe) -> HOLD (data held,
// ack pulse). A bank-wide clear takes priority over transfers in IDLE.
// Every output is a flop; outputs are derived from the next state.
module reg_bank_bus_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input logic                   clk,
    input logic                   clr_n,
    reg_bank_bus_arbiter_if.slave bus
);
    localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DSTW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   rr_q, rr_d;
    logic [DSTW-1:0] dst_q, dst_d;
    logic [DW-1:0]   bus_data_q, bus_data_d;
    logic [SW-1:0]   bus_sel_q, bus_sel_d;
    logic [NREG-1:0] reg_load_q, reg_load_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            bank_clr_n_q, bank_clr_n_d;
    logic            busy_q, busy_d;

    logic            any_req;
    logic [SW-1:0]   arb_win;

    // Round-robin pick: scan from the pointer upward with wrap; the lowest
    // offset from the pointer wins, so iterate downward and let it override.
    always_comb begin
        int idx;
        any_req = 1'b0;
        arb_win = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (bus.req[idx]) begin
                any_req = 1'b1;
                arb_win = SW'(idx);
            end
        end
    end

    // Next-state, transfer latches and registered-output next values.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        dst_d      = dst_q;
        bus_data_d = bus_data_q;
        bus_sel_d  = bus_sel_q;

        case (state_q)
            S_IDLE: begin
                if (bus.clr_req) begin
                    state_d = S_CLEAR;
                end else if (any_req) begin
                    state_d    = S_SETUP;
                    bus_sel_d  = arb_win;
                    dst_d      = bus.req_dst[int'(arb_win)*DSTW +: DSTW];
                    bus_data_d = bus.req_data[int'(arb_win)*DW +: DW];
                end
            end
            S_SETUP: state_d = S_LOAD;
            S_LOAD:  state_d = S_HOLD;
            S_HOLD: begin
                state_d = S_IDLE;
                rr_d    = (bus_sel_q == SW'(NREQ - 1)) ? '0 : bus_sel_q + SW'(1);
            end
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        bank_clr_n_d = (state_d != S_CLEAR);
        reg_load_d   = '0;
        for (int r = 0; r < NREG; r++) begin
            reg_load_d[r] = (state_d == S_LOAD) && (dst_q == DSTW'(r));
        end
        ack_d = '0;
        for (int a = 0; a < NREQ; a++) begin
            ack_d[a] = (state_d == S_HOLD) && (bus_sel_q == SW'(a));
        end
    end

    // State and output registers; reset clears the bank and aborts any transfer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            dst_q        <= '0;
            bus_data_q   <= '0;
            bus_sel_q    <= '0;
            reg_load_q   <= '0;
            ack_q        <= '0;
            bank_clr_n_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            dst_q        <= dst_d;
            bus_data_q   <= bus_data_d;
            bus_sel_q    <= bus_sel_d;
            reg_load_q   <= reg_load_d;
            ack_q        <= ack_d;
            bank_clr_n_q <= bank_clr_n_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.bus_data   = bus_data_q;
    assign bus.bus_sel    = bus_sel_q;
    assign bus.reg_load   = reg_load_q;
    assign bus.bank_clr_n = bank_clr_n_q;
    assign bus.busy       = busy_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_reg_bank_bus_arbiter.sv
// Directed bench for reg_bank_bus_arbiter (NREQ=4, NREG=8, DW=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_bank_bus_arbiter;
    logic clk;
    logic clr_n;
    int   total;
    int   bad;
    int   cyc;

    reg_bank_bus_arbiter_if #(.NREQ(4), .NREG(8), .DW(8)) bus_if ();

    reg_bank_bus_arbiter #(.NREQ(4), .NREG(8), .DW(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [3:0]  req;
        logic [11:0] dst;
        logic [31:0] data;
        logic [1:0]  exp_sel;
        logic [7:0]  exp_load;
        logic [7:0]  exp_data;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs [8];

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [11:0] d, input logic [31:0] x);
        bus_if.req      = r;
        bus_if.req_dst  = d;
        bus_if.req_data = x;
    endtask

    initial begin
        int cnt;
        int last_ack;
        logic [7:0] acc_load;
        logic [3:0] acc_ack;
        logic       acc_busy;

        total = 0;
        bad   = 0;
        cyc   = 0;
        clr_n = 1'b0;
        bus_if.clr_req = 1'b0;
        drive(4'b0000, 12'h000, 32'h0);

        // Vectors; rr pointer carries over from one record to the next.
        vecs[0] = '{4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, {8'h00, 8'hA7, 8'h00, 8'h00}, 2'd2, 8'b0010_0000, 8'hA7, 4'b0100};
        vecs[1] = '{4'b1000, {3'd7, 3'd1, 3'd1, 3'd1}, {8'h5A, 8'h11, 8'h22, 8'h33}, 2'd3, 8'b1000_0000, 8'h5A, 4'b1000};
        vecs[2] = '{4'b1001, {3'd6, 3'd0, 3'd0, 3'd2}, {8'hF0, 8'h00, 8'h00, 8'h0F}, 2'd0, 8'b0000_0100, 8'h0F, 4'b0001};
        vecs[3] = '{4'b1001, {3'd6, 3'd0, 3'd0, 3'd2}, {8'hF0, 8'h00, 8'h00, 8'h0F}, 2'd3, 8'b0100_0000, 8'hF0, 4'b1000};
        vecs[4] = '{4'b0110, {3'd0, 3'd3, 3'd4, 3'd0}, {8'h00, 8'hC3, 8'h81, 8'h00}, 2'd1, 8'b0001_0000, 8'h81, 4'b0010};
        vecs[5] = '{4'b0110, {3'd0, 3'd3, 3'd4, 3'd0}, {8'h00, 8'hC3, 8'h81, 8'h00}, 2'd2, 8'b0000_1000, 8'hC3, 4'b0100};
        vecs[6] = '{4'b0011, {3'd0, 3'd0, 3'd1, 3'd7}, {8'h00, 8'h00, 8'h99, 8'h66}, 2'd0, 8'b1000_0000, 8'h66, 4'b0001};
        vecs[7] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, {8'h00, 8'h00, 8'h00, 8'hFF}, 2'd0, 8'b0000_0001, 8'hFF, 4'b0001};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_ack", 32'(bus_if.ack), 32'd0);
        check("rst_load", 32'(bus_if.reg_load), 32'd0);
        check("rst_data", 32'(bus_if.bus_data), 32'd0);
        check("rst_sel", 32'(bus_if.bus_sel), 32'd0);
        check("rst_clr", 32'(bus_if.bank_clr_n), 32'd0);
        clr_n = 1'b1;
        #1 check("rst_clr_pre_edge", 32'(bus_if.bank_clr_n), 32'd0);
        @(negedge clk);
        check("rst_clr_released", 32'(bus_if.bank_clr_n), 32'd1);

        // Table-driven transfers, back to back.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].req, vecs[i].dst, vecs[i].data);
            @(negedge clk);
            check($sformatf("v%0d_setup_data", i), 32'(bus_if.bus_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_setup_sel", i), 32'(bus_if.bus_sel), 32'(vecs[i].exp_sel));
            check($sformatf("v%0d_setup_load", i), 32'(bus_if.reg_load), 32'd0);
            check($sformatf("v%0d_setup_busy", i), 32'(bus_if.busy), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_load", i), 32'(bus_if.reg_load), 32'(vecs[i].exp_load));
            check($sformatf("v%0d_load_ack", i), 32'(bus_if.ack), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_ack", i), 32'(bus_if.ack), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_hold_load", i), 32'(bus_if.reg_load), 32'd0);
            check($sformatf("v%0d_hold_data", i), 32'(bus_if.bus_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_hold_busy", i), 32'(bus_if.busy), 32'd1);
            bus_if.req = 4'b0000;
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", i), 32'(bus_if.busy), 32'd0);
            check($sformatf("v%0d_idle_ack", i), 32'(bus_if.ack), 32'd0);
            check($sformatf("v%0d_idle_data", i), 32'(bus_if.bus_data), 32'(vecs[i].exp_data));
        end

        // Clear has priority over a simultaneous request.
        bus_if.clr_req = 1'b1;
        drive(4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, {8'h00, 8'h00, 8'h4B, 8'h00});
        @(negedge clk);
        check("clr_low", 32'(bus_if.bank_clr_n), 32'd0);
        check("clr_no_load", 32'(bus_if.reg_load), 32'd0);
        check("clr_busy", 32'(bus_if.busy), 32'd1);
        check("clr_data_kept", 32'(bus_if.bus_data), 32'hFF);
        bus_if.clr_req = 1'b0;
        @(negedge clk);
        check("clr_done", 32'(bus_if.bank_clr_n), 32'd1);
        check("clr_idle_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        check("clr_then_sel", 32'(bus_if.bus_sel), 32'd1);
        check("clr_then_data", 32'(bus_if.bus_data), 32'h4B);
        @(negedge clk);
        check("clr_then_load", 32'(bus_if.reg_load), 32'b0000_0100);
        @(negedge clk);
        check("clr_then_ack", 32'(bus_if.ack), 32'b0010);
        bus_if.req = 4'b0000;
        @(negedge clk);

        // Early drop: one-cycle request still completes, and only once.
        drive(4'b0001, 12'h000, {8'h00, 8'h00, 8'h00, 8'h3C});
        @(negedge clk);
        bus_if.req = 4'b0000;
        check("early_data", 32'(bus_if.bus_data), 32'h3C);
        check("early_busy", 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        check("early_load", 32'(bus_if.reg_load), 32'b0000_0001);
        @(negedge clk);
        check("early_ack", 32'(bus_if.ack), 32'b0001);
        acc_load = '0;
        acc_ack  = '0;
        acc_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            acc_load = acc_load | bus_if.reg_load;
            acc_ack  = acc_ack | bus_if.ack;
            acc_busy = acc_busy | bus_if.busy;
        end
        check("early_no_second_load", 32'(acc_load), 32'd0);
        check("early_no_second_ack", 32'(acc_ack), 32'd0);
        check("early_no_second_busy", 32'(acc_busy), 32'd0);

        // Reset asserted in the middle of LOAD aborts the transfer.
        drive(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, {8'h00, 8'hA7, 8'h00, 8'h00});
        @(negedge clk);
        @(negedge clk);
        check("abort_load_seen", 32'(bus_if.reg_load), 32'b0010_0000);
        #2 clr_n = 1'b0;
        #1;
        check("abort_load", 32'(bus_if.reg_load), 32'd0);
        check("abort_ack", 32'(bus_if.ack), 32'd0);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_clr", 32'(bus_if.bank_clr_n), 32'd0);
        check("abort_data", 32'(bus_if.bus_data), 32'd0);
        bus_if.req = 4'b0000;
        @(negedge clk);
        clr_n = 1'b1;
        #1 check("abort_clr_pre_edge", 32'(bus_if.bank_clr_n), 32'd0);
        @(negedge clk);
        check("abort_clr_released", 32'(bus_if.bank_clr_n), 32'd1);
        acc_ack = '0;
        repeat (6) begin
            @(negedge clk);
            acc_ack = acc_ack | bus_if.ack;
        end
        check("abort_no_ack", 32'(acc_ack), 32'd0);

        // Round-robin with all requesters active, pointer starts at 0.
        drive(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, {8'h44, 8'h33, 8'h22, 8'h11});
        last_ack = 0;
        for (int g = 0; g < 6; g++) begin
            cnt = 0;
            while (bus_if.ack == 4'b0000 && cnt < 12) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("rr%0d_wait_ok", g), 32'(cnt < 12), 32'd1);
            check($sformatf("rr%0d_ack", g), 32'(bus_if.ack), 32'(4'b0001 << (g % 4)));
            if (g > 0) check($sformatf("rr%0d_spacing", g), 32'(cyc - last_ack), 32'd4);
            last_ack = cyc;
            bus_if.req[g % 4] = 1'b0;
            @(negedge clk);
            bus_if.req[g % 4] = 1'b1;
        end
        bus_if.req = 4'b0000;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
